deserializer_1to32: RTL
=======================

# deserializer_1to32

Serial-to-parallel word builder, the write-side counterpart of the 32-to-1 bit select mux. It accepts one data bit per handshake and places it into a 32-bit word, either at an auto-incrementing position or at an explicitly addressed position. When all 32 positions have been written, or on an early flush, it presents the word on a valid/ready output. It sits between a serial bit source (shift/test path) and any 32-bit consumer, including the bit-select mux.

## Interface
Parameters: none (width fixed at 32, index at 5 bits).
- CLK  in  1  rising-edge clock
- RSTn  in  1  reset; one clock, reset is asynchronous and active-low
- D  in  1  serial data bit
- D_valid  in  1  D (and S/MODE/FLUSH) valid this cycle
- D_ready  out  1  block can accept a bit; high exactly when state = FILL
- MODE  in  1  0 = auto-index (position from internal counter), 1 = addressed (position = S)
- S  in  5  target bit position when MODE = 1; ignored when MODE = 0
- FLUSH  in  1  complete the current word early; sampled only with an accepted bit or alone in FILL
- X  out  32  assembled word; meaningful only while X_valid = 1
- X_valid  out  1  word available
- X_ready  in  1  consumer takes word
- IDX  out  5  current auto-index value (debug)

## Operation
- Internal state: word register W[31:0], written-mask M[31:0], auto-index IDX[4:0], FSM state FILL/FULL.
- Accept = D_valid & D_ready.
- On accept, the write position is P = MODE ? S : IDX. Next-cycle values:
  - W[P] <= D.
  - M[P] <= 1.
  - If MODE = 0: IDX <= IDX + 1, wrapping 31 -> 0.
  - If MODE = 1: IDX holds.
- Rewriting an already written position overwrites W[P]; M is unchanged and the bit is not double-counted.
- Completion: after any accept, if the updated M = 32'hFFFFFFFF, go to FULL.
- Flush:
  - FLUSH = 1 in FILL with M (including any same-cycle write) != 0 goes to FULL.
  - Unwritten bits of W are 0.
  - FLUSH with M = 0 and no accept is ignored.
- FULL: X = W, X_valid = 1, D_ready = 0. D, S, MODE and FLUSH are ignored.
- FULL & X_ready: next cycle W <= 0, M <= 0, IDX <= 0, state <= FILL, X_valid <= 0.
- MODE may change between accepted bits. Completion is always decided by M, never by IDX.
- X_valid, once high, stays high with X stable until X_ready.

## Timing
- Reset (asynchronous assert, synchronous-to-CLK deassert use):
  - State FILL; W = 0, M = 0, IDX = 0.
  - X = 0, X_valid = 0, D_ready = 1.
- All outputs are registered except D_ready, which is decoded from the state register. There is no combinational path from inputs to outputs.
- Latency: X_valid rises on the cycle after the accept that fills M (or after the accepted flush).
- Minimum word period in MODE 0: 32 accepts + 1 FULL cycle when X_ready is held high.
- One-cycle bubble: D_ready returns on the cycle after the X_ready handshake. No bit is accepted in the handshake cycle.
- Reset asserted mid-word or in FULL: partial word discarded, outputs at reset values immediately.

## Test plan
- Reset, then MODE=0, stream 32 bits of 32'hA5A5_0F3C, LSB first, D_valid held high, X_ready=0:
  - X_valid rises 1 cycle after the 32nd accept, with X = 32'hA5A5_0F3C.
  - D_ready = 0 while X_valid is high.
  - Assert X_ready: X_valid drops, D_ready returns next cycle, IDX = 0.
- MODE=1, write D=1 at S = 31, 0, 16, then the remaining 29 positions with D=0 in descending order. Expect X = 32'h8001_0001 after the 32nd distinct position.
- MODE=1, write S=5 four times with D=1,0,1,1, then FLUSH with no bit. Expect X = 32'h0000_0020, and FULL entered only on the flush.
- MODE=0, accept 3 bits 1,1,0 with FLUSH on the 3rd accept. Expect X = 32'h0000_0003 next cycle.
- FLUSH alone right after reset: no X_valid, D_ready stays 1.
- MODE=0, accept 10 bits, assert RSTn low mid-stream, release, then stream 32 ones. Expect X = 32'hFFFF_FFFF with no residue from the first stream. D_valid pulses with gaps must give the same result.

Source files
------------

// File: rtl/deserializer_1to32.sv
// rtl/deserializer_1to32.sv - serial-to-parallel 32-bit word builder
//
// Collects one bit per D_valid/D_ready handshake into a 32-bit word, either at
// an auto-incrementing position (MODE=0) or at an addressed position S (MODE=1).
// The word is presented on X/X_valid once every position has been written, or
// earlier on FLUSH, and held until the consumer accepts it with X_ready.
//
// Ports:
//   CLK      in   rising-edge clock
//   RSTn     in   asynchronous active-low reset
//   D        in   serial data bit
//   D_valid  in   D, S, MODE, FLUSH valid this cycle
//   D_ready  out  high while filling (decoded from state)
//   MODE     in   0 = auto-index, 1 = addressed by S
//   S        in   [4:0] bit position used when MODE = 1
//   FLUSH    in   finish the current word early (needs at least one written bit)
//   X        out  [31:0] assembled word, meaningful while X_valid = 1
//   X_valid  out  word available
//   X_ready  in   consumer takes the word
//   IDX      out  [4:0] current auto-index (debug)

module deserializer_1to32 (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        D,
    input  logic        D_valid,
    output logic        D_ready,
    input  logic        MODE,
    input  logic [4:0]  S,
    input  logic        FLUSH,
    output logic [31:0] X,
    output logic        X_valid,
    input  logic        X_ready,
    output logic [4:0]  IDX
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e      state_q;
    logic [31:0] w_q;
    logic [31:0] m_q;
    logic [4:0]  idx_q;
    logic        x_valid_q;

    logic [31:0] w_d;
    logic [31:0] m_d;
    logic [4:0]  idx_d;
    logic [4:0]  pos;
    logic        accept;
    logic        full_d;

    // Next word/mask/index as they would be after this cycle's accept. The
    // completion test looks at the updated mask so that the bit arriving this
    // cycle counts, and a rewrite of an already written position leaves the
    // mask (and thus the completion decision) unchanged.
    always_comb begin
        accept = D_valid && (state_q == FILL);
        pos    = MODE ? S : idx_q;
        w_d    = w_q;
        m_d    = m_q;
        idx_d  = idx_q;
        if (accept) begin
            w_d[pos] = D;
            m_d[pos] = 1'b1;
            if (!MODE) begin
                idx_d = idx_q + 5'd1;
            end
        end
        // FLUSH counts with an accepted bit or alone, but only once something
        // has been written; an empty flush is dropped.
        full_d = (state_q == FILL) &&
                 ((accept && (&m_d)) || (FLUSH && (|m_d)));
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= FILL;
            w_q       <= 32'h0;
            m_q       <= 32'h0;
            idx_q     <= 5'd0;
            x_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    w_q   <= w_d;
                    m_q   <= m_d;
                    idx_q <= idx_d;
                    if (full_d) begin
                        state_q   <= FULL;
                        x_valid_q <= 1'b1;
                    end
                end
                FULL: begin
                    // Word and mask are frozen here; inputs are ignored until
                    // the consumer handshake, which costs one bubble cycle.
                    if (X_ready) begin
                        state_q   <= FILL;
                        w_q       <= 32'h0;
                        m_q       <= 32'h0;
                        idx_q     <= 5'd0;
                        x_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= FILL;
                    x_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Unwritten bits stay 0 because W is cleared at reset and on every handoff.
    assign X       = w_q;
    assign X_valid = x_valid_q;
    assign D_ready = (state_q == FILL);
    assign IDX     = idx_q;

endmodule
